// File: rtl/video_timing_ctrl_if.sv
// Raster timing bundle between the timing controller and its consumers
// (TMDS encoders, pixel renderer, game logic).
interface video_timing_ctrl_if;
    logic        en_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        active_draw_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hsync_d_out;
    logic        vsync_d_out;
    logic        active_draw_d_out;
    logic        new_frame_out;
    logic [5:0]  frame_count_out;
    logic        running_out;

    modport master (
        input  en_in,
        output hcount_out, vcount_out, active_draw_out, hsync_out, vsync_out,
               hsync_d_out, vsync_d_out, active_draw_d_out, new_frame_out,
               frame_count_out, running_out
    );

    modport slave (
        output en_in,
        input  hcount_out, vcount_out, active_draw_out, hsync_out, vsync_out,
               hsync_d_out, vsync_d_out, active_draw_d_out, new_frame_out,
               frame_count_out, running_out
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: h/v counters, sync/active strobes with a renderer-latency
// delay line, and a per-frame pulse/counter. Starts and stops on frame bounds.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter int unsigned PIPE_DEPTH = 4
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    video_timing_ctrl_if.master vt
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_NF   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        act_q, act_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        nf_q, nf_d;
    logic        running_q, running_d;
    logic [5:0]  fc_q, fc_d;
    logic        last_px;

    // Strobes are decoded from the next counter values so every registered
    // output lines up with the counters shown in the same cycle.
    always_comb begin
        state_d  = state_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        last_px  = (hcount_q == H_LAST) && (vcount_q == V_LAST);
        case (state_q)
            IDLE: begin
                hcount_d = '0;
                vcount_d = '0;
                if (vt.en_in) state_d = RUN;
            end
            default: begin
                if (hcount_q == H_LAST) begin
                    hcount_d = '0;
                    vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
                end else begin
                    hcount_d = hcount_q + 11'd1;
                end
                if (vt.en_in)     state_d = RUN;
                else if (last_px) state_d = IDLE;
                else              state_d = DRAIN;
            end
        endcase
        running_d = (state_d != IDLE);
        act_d = running_d && (hcount_d < H_ACT) && (vcount_d < V_ACT);
        hs_d  = running_d && (hcount_d >= HS_BEG) && (hcount_d <= HS_END);
        vs_d  = running_d && (vcount_d >= VS_BEG) && (vcount_d <= VS_END);
        nf_d  = running_d && (hcount_d == H_ACT) && (vcount_d == V_NF);
        fc_d  = fc_q + 6'(nf_d);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            hcount_q  <= '0;
            vcount_q  <= '0;
            act_q     <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            nf_q      <= 1'b0;
            running_q <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            act_q     <= act_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            nf_q      <= nf_d;
            running_q <= running_d;
            fc_q      <= fc_d;
        end
    end

    // Delay line carries {hsync, vsync, active}; strobes are 0 in IDLE so it
    // flushes itself after a stop.
    logic [2:0] dly_out;

    generate
        if (PIPE_DEPTH == 0) begin : g_nodly
            assign dly_out = {hs_q, vs_q, act_q};
        end else begin : g_dly
            logic [PIPE_DEPTH-1:0][2:0] dly_q, dly_d;

            always_comb begin
                dly_d    = dly_q;
                dly_d[0] = {hs_q, vs_q, act_q};
                for (int i = 1; i < int'(PIPE_DEPTH); i++) dly_d[i] = dly_q[i-1];
            end

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) dly_q <= '0;
                else           dly_q <= dly_d;
            end

            assign dly_out = dly_q[PIPE_DEPTH-1];
        end
    endgenerate

    assign vt.hcount_out        = hcount_q;
    assign vt.vcount_out        = vcount_q;
    assign vt.active_draw_out   = act_q;
    assign vt.hsync_out         = hs_q;
    assign vt.vsync_out         = vs_q;
    assign vt.new_frame_out     = nf_q;
    assign vt.frame_count_out   = fc_q;
    assign vt.running_out       = running_q;
    assign vt.hsync_d_out       = dly_out[2];
    assign vt.vsync_d_out       = dly_out[1];
    assign vt.active_draw_d_out = dly_out[0];
endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Sequencer for the HDMI output path. It generates the raster scan that the TMDS encoders and the pixel renderer both consume:
- horizontal/vertical counters;
- sync and active-draw strobes, plus copies delayed to match renderer latency;
- a per-frame handshake for game logic.

It sits between the pixel-clock domain's clock wizard and the graphics pipeline. It replaces ad-hoc sync generation and controls when video starts and stops, always on frame boundaries.

## Interface
Parameters (defaults are 1280x720p60):
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, hsync width (cycles)
- H_BP, 220, horizontal back porch (cycles)
- V_ACTIVE, 720, visible lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- PIPE_DEPTH, 4, renderer latency in cycles; 0 is legal (delayed outputs equal undelayed)

Derived values: H_TOTAL = sum of the H terms (1650); V_TOTAL = sum of the V terms (750).

Ports:
- clk_in, input, 1, pixel clock
- rst_n_in, input, 1, reset, asynchronous and active-low
- en_in, input, 1, level request to run video
- hcount_out, output, 11, current column
- vcount_out, output, 10, current line
- active_draw_out, output, 1, current pixel is visible
- hsync_out, output, 1, horizontal sync, active-high
- vsync_out, output, 1, vertical sync, active-high
- hsync_d_out, output, 1, hsync_out delayed PIPE_DEPTH cycles
- vsync_d_out, output, 1, vsync_out delayed PIPE_DEPTH cycles
- active_draw_d_out, output, 1, active_draw_out delayed PIPE_DEPTH cycles
- new_frame_out, output, 1, one-cycle pulse at the start of vertical blanking
- frame_count_out, output, 6, frames completed; wraps modulo 64
- running_out, output, 1, high in RUN and DRAIN

## Operation
States:
- **IDLE**
  - Counters held at 0.
  - All strobes and running_out are 0; strobes are masked even though hcount = vcount = 0.
  - en_in = 1 → RUN.
- **RUN**
  - Raster advances every cycle.
  - en_in = 0 → DRAIN.
- **DRAIN**
  - Raster keeps advancing.
  - en_in = 1 → RUN, with no disturbance to the counters.
  - On the last pixel (hcount = H_TOTAL-1, vcount = V_TOTAL-1) → IDLE, counters return to 0.

Counters:
- hcount increments every cycle in RUN/DRAIN. At H_TOTAL-1 it wraps to 0 and vcount increments.
- vcount wraps from V_TOTAL-1 to 0.
- No other values are ever reachable.

Decode (all outputs are registered and mutually aligned, so every strobe describes the hcount/vcount shown in the same cycle):
- active_draw_out = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- hsync_out = 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], on every line including blanking lines.
- vsync_out = 1 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for entire lines.

Frame handshake:
- new_frame_out pulses for one cycle when hcount = H_ACTIVE and vcount = V_ACTIVE - 1. This is the first cycle after the final visible pixel.
- frame_count_out increments in the same cycle as the pulse, wrapping 63 → 0.

Delay line:
- A PIPE_DEPTH-stage shift register carries {hsync, vsync, active_draw}.
- All stages reset to 0.
- During IDLE the line is fed zeros, so it drains naturally after a stop.

## Timing
- Reset (asynchronous assert, synchronous-release usage assumed upstream):
  - all outputs 0;
  - state IDLE;
  - delay line cleared.
- Start latency: en_in sampled high at edge k while in IDLE. In the cycle after edge k:
  - running_out = 1;
  - hcount = vcount = 0;
  - active_draw_out = 1.
- Pixel (h, v) is presented exactly h + v·H_TOTAL cycles after that first cycle.
- Delayed strobes lag their undelayed versions by exactly PIPE_DEPTH cycles.
- Stop:
  - en_in low mid-frame: the frame completes.
  - The cycle after the last pixel shows IDLE, running_out = 0, counters = 0.
  - en_in low exactly on the last-pixel cycle also ends in IDLE next cycle.
- en_in toggling inside a frame (RUN ↔ DRAIN) never alters counters or strobes.
- Reset asserted mid-frame: all outputs drop to 0 immediately (asynchronous). frame_count_out returns to 0.
- Counter widths are sufficient for H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024; larger parameter values are illegal.

## Test plan
All scenarios use small parameters: H = 8/2/3/3 (H_TOTAL 16), V = 4/1/2/1 (V_TOTAL 8), PIPE_DEPTH 2.

1. **Reset:** hold rst_n_in = 0 with en_in = 1 → every output is 0. Release and pulse en_in at edge k → at edge k+1, running_out = 1, hcount = 0, vcount = 0, active_draw_out = 1.
2. **Line decode:** in line 0 → active_draw_out = 1 for hcount 0–7 and 0 for 8–15; hsync_out = 1 exactly at hcount 10, 11, 12. hsync_d_out is the same pattern two cycles later.
3. **Frame decode:** over one frame → vsync_out = 1 for all 32 cycles of lines 5–6. active_draw_out is never 1 on lines 4–7. new_frame_out pulses exactly once, at (8, 3).
4. **Frame counter:** run 65 frames → frame_count_out reads 1 after the first pulse and wraps to 0 then 1 at pulses 64 and 65. The pulse spacing is 128 cycles.
5. **Stop:**
   - Drop en_in at (3, 2) → counters continue to (15, 7), then IDLE with counters 0 and running_out = 0. active_draw_d_out reaches 0 two cycles after active_draw_out does.
   - Repeat, but raise en_in again at (5, 6) → no discontinuity, and the next frame starts at (0, 0).
6. **Reset mid-frame:** assert rst_n_in low at (6, 1) → all outputs read 0 before the next clock edge; frame_count_out = 0.
